mbe_mult_pipe: RTL and testbench

MBE_MULT_PIPE -- requirements
Module: mbe_mult_pipe

---
 rtl/mbe_mult_if.sv | 21 ++
 rtl/mbe_mult_pipe.sv | 85 ++++++++
 tb/tb_mbe_mult_pipe.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mbe_mult_if.sv
// mbe_mult_if: valid/ready operand and product channels of the Booth multiplier
interface mbe_mult_if #(parameter int N = 12, parameter int TAGW = 4);
    logic            in_valid;
    logic            in_ready;
    logic [N-1:0]    a;
    logic [N-1:0]    b;
    logic            is_signed;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [2*N-1:0]  product;
    logic [TAGW-1:0] out_tag;
    modport slave (
        input  in_valid, a, b, is_signed, in_tag, out_ready,
        output in_ready, out_valid, product, out_tag
    );
    modport master (
        output in_valid, a, b, is_signed, in_tag, out_ready,
        input  in_ready, out_valid, product, out_tag
    );
endinterface

// File: rtl/mbe_mult_pipe.sv
// mbe_mult_pipe: 3-stage radix-4 Modified Booth multiplier, signed/unsigned per operation
module mbe_mult_pipe #(
    parameter int N    = 12,
    parameter int TAGW = 4
) (
    input logic      clk,
    input logic      rst,
    mbe_mult_if.slave bus
);
    localparam int R = N / 2 + 1;
    localparam int W = 2 * N;
    logic            adv;
    logic [W-1:0]    pp [R];
    logic [R-1:0]    ng;
    logic [W-1:0]    red_s, red_c;
    logic            s1_v, s2_v, s3_v;
    logic            s1_sg, s2_sg, s3_sg;
    logic [TAGW-1:0] s1_tag, s2_tag, s3_tag;
    logic [W-1:0]    s1_pp [R];
    logic [R-1:0]    s1_ng;
    logic [W-1:0]    s2_s, s2_c, s3_p;
    assign adv           = !s3_v || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = s3_v;
    assign bus.product   = s3_p;
    assign bus.out_tag   = s3_tag;
    // Sign-extending b in signed mode makes the extra top digit zero, so one row count serves both modes
    always_comb begin : booth
        logic          ext;
        logic [N+2:0]  bx;
        logic [W-1:0]  ax, m;
        logic [2:0]    t;
        ext = bus.is_signed & bus.b[N-1];
        bx  = {ext, ext, bus.b, 1'b0};
        ax  = {{N{bus.is_signed & bus.a[N-1]}}, bus.a};
        m   = '0;
        t   = '0;
        for (int i = 0; i < R; i++) begin
            t     = bx[2*i +: 3];
            m     = (t[0] ^ t[1]) ? ax : ((t == 3'b011) || (t == 3'b100)) ? ax << 1 : '0;
            pp[i] = (t[2] ? ~m : m) << (2 * i);
            ng[i] = t[2];
        end
    end
    // The +1 of each negated row sits at bit 2i and forms one extra row for the 3:2 reduction
    always_comb begin : reduce
        logic [W-1:0] t;
        red_s = '0;
        red_c = '0;
        t     = '0;
        for (int i = 0; i < R; i++) red_s[2*i] = s1_ng[i];
        for (int i = 0; i < R; i++) begin
            t     = red_s ^ red_c ^ s1_pp[i];
            red_c = ((red_s & red_c) | (red_s & s1_pp[i]) | (red_c & s1_pp[i])) << 1;
            red_s = t;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {s1_v, s2_v, s3_v}       <= '0;
            {s1_sg, s2_sg, s3_sg}    <= '0;
            {s1_tag, s2_tag, s3_tag} <= '0;
            s1_pp <= '{default: '0};
            s1_ng <= '0;
            s2_s  <= '0;
            s2_c  <= '0;
            s3_p  <= '0;
        end else if (adv) begin
            s1_v   <= bus.in_valid;
            s1_sg  <= bus.is_signed;
            s1_tag <= bus.in_tag;
            s1_pp  <= pp;
            s1_ng  <= ng;
            s2_v   <= s1_v;
            s2_sg  <= s1_sg;
            s2_tag <= s1_tag;
            s2_s   <= red_s;
            s2_c   <= red_c;
            s3_v   <= s2_v;
            s3_sg  <= s2_sg;
            s3_tag <= s2_tag;
            s3_p   <= s2_c + s2_s;
        end
    end
endmodule

// File: tb/tb_mbe_mult_pipe.sv
// tb_mbe_mult_pipe: directed corners, backpressure, reset and random traffic against a queue-based multiply model
module tb_mbe_mult_pipe;
    localparam int N    = 12;
    localparam int TAGW = 4;
    localparam int W    = 2 * N;
    typedef struct {logic [W-1:0] p; logic [TAGW-1:0] t;} exp_t;
    logic clk = 0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    logic            held = 0;
    logic [W-1:0]    hp;
    logic [TAGW-1:0] ht;
    mbe_mult_if #(.N(N), .TAGW(TAGW)) bus ();
    mbe_mult_pipe #(.N(N), .TAGW(TAGW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    initial begin
        #50;
        forever #5 clk = ~clk;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
    function automatic logic [W-1:0] mul(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
        longint lx, ly;
        lx = s ? longint'($signed(x)) : longint'(x);
        ly = s ? longint'($signed(y)) : longint'(y);
        return W'(lx * ly);
    endfunction
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask
    task automatic send(input logic [N-1:0] x, input logic [N-1:0] y, input logic s, input logic [TAGW-1:0] tg);
        logic ok;
        int   n = 0;
        bus.in_valid  = 1;
        bus.a         = x;
        bus.b         = y;
        bus.is_signed = s;
        bus.in_tag    = tg;
        do begin
            #4;
            ok = bus.in_ready;
            @(negedge clk);
            n++;
        end while (!ok && n < 100);
        if (!ok) chk("send_timeout", 0, 1);
    endtask
    // Scoreboard: every cycle, just before the rising edge, check handshake rules, held outputs and in-order results
    always begin
        @(negedge clk);
        #4;
        if (rst) begin
            q.delete();
            held = 0;
        end else begin
            chk("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
            if (held) begin
                chk("hold_product", bus.product, hp);
                chk("hold_tag", bus.out_tag, ht);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) chk("spurious_output", 1, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("product", bus.product, e.p);
                    chk("out_tag", bus.out_tag, e.t);
                end
            end
            held = bus.out_valid && !bus.out_ready;
            hp   = bus.product;
            ht   = bus.out_tag;
            if (bus.in_valid && bus.in_ready)
                q.push_back('{mul(bus.a, bus.b, bus.is_signed), bus.in_tag});
        end
    end
    initial begin
        logic acc;
        rst = 1;
        bus.in_valid = 0; bus.a = 0; bus.b = 0; bus.is_signed = 0; bus.in_tag = 0; bus.out_ready = 1;
        #10;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_product", bus.product, 0);
        chk("rst_out_tag", bus.out_tag, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        // signed corners, back to back
        send(12'h800, 12'h800, 1, 4'd1);
        send(12'h7FF, 12'hFFF, 1, 4'd2);
        chk("lat_not_yet", bus.out_valid, 0);
        send(12'h000, 12'd123, 1, 4'd3);
        bus.in_valid = 0;
        chk("sc1_valid", bus.out_valid, 1);
        chk("sc1_product", bus.product, 24'h400000);
        chk("sc1_tag", bus.out_tag, 1);
        @(negedge clk);
        chk("sc2_valid", bus.out_valid, 1);
        chk("sc2_product", bus.product, 24'hFFF801);
        chk("sc2_tag", bus.out_tag, 2);
        @(negedge clk);
        chk("sc3_valid", bus.out_valid, 1);
        chk("sc3_product", bus.product, 24'h000000);
        chk("sc3_tag", bus.out_tag, 3);
        @(negedge clk);
        chk("sc_drained", bus.out_valid, 0);
        // unsigned corners
        send(12'hFFF, 12'hFFF, 0, 4'd5);
        send(12'd57, 12'd1234, 0, 4'd6);
        bus.in_valid = 0;
        @(negedge clk);
        chk("uc1_product", bus.product, 24'd16769025);
        chk("uc1_tag", bus.out_tag, 5);
        @(negedge clk);
        chk("uc2_product", bus.product, 24'd70338);
        chk("uc2_tag", bus.out_tag, 6);
        repeat (3) @(negedge clk);
        // backpressure: stall 4 cycles once the first result appears
        for (int i = 0; i < 3; i++) send(12'(100 + i), 12'(3 * i + 1), i[0], 4'(8 + i));
        bus.out_ready = 0;
        bus.a = 12'd777; bus.b = 12'hF00; bus.is_signed = 1; bus.in_tag = 4'd11;
        repeat (4) begin
            #4;
            chk("stall_in_ready", bus.in_ready, 0);
            chk("stall_out_valid", bus.out_valid, 1);
            @(negedge clk);
        end
        bus.out_ready = 1;
        send(12'd777, 12'hF00, 1, 4'd11);
        send(12'hABC, 12'h123, 0, 4'd12);
        send(12'h800, 12'h7FF, 1, 4'd13);
        bus.in_valid = 0;
        repeat (8) @(negedge clk);
        chk("bp_queue_empty", q.size(), 0);
        // reset with three operations in flight
        for (int i = 0; i < 3; i++) send(12'(5 + i), 12'(9 + i), 0, 4'(i + 1));
        bus.in_valid = 0;
        #2 rst = 1;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_product", bus.product, 0);
        chk("mid_rst_out_tag", bus.out_tag, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        repeat (2) @(negedge clk);
        rst = 0;
        send(12'hFFD, 12'd7, 1, 4'd9);
        bus.in_valid = 0;
        chk("post_rst_idle1", bus.out_valid, 0);
        @(negedge clk);
        chk("post_rst_idle2", bus.out_valid, 0);
        @(negedge clk);
        chk("post_rst_valid", bus.out_valid, 1);
        chk("post_rst_product", bus.product, 24'hFFFFEB);
        chk("post_rst_tag", bus.out_tag, 9);
        @(negedge clk);
        // random mixed traffic with a holding source
        acc = 1;
        for (int i = 0; i < 3000; i++) begin
            if (!bus.in_valid || acc) begin
                bus.in_valid  = $urandom_range(0, 3) != 0;
                bus.a         = ($urandom_range(0, 7) == 0) ? 12'h800 : ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom);
                bus.b         = ($urandom_range(0, 7) == 0) ? 12'h800 : ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom);
                bus.is_signed = 1'($urandom);
                bus.in_tag    = 4'($urandom);
            end
            bus.out_ready = $urandom_range(0, 3) != 0;
            #4;
            acc = bus.in_ready;
            @(negedge clk);
        end
        bus.in_valid  = 0;
        bus.out_ready = 1;
        repeat (6) @(negedge clk);
        chk("rand_queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
